// File: rtl/axi_slv_port_demux.sv
// axi_slv_port_demux
// Slave-port front end of the AXI4 crossbar. Every AW/AR address is decoded
// against the rule map. The transaction then goes to one of NoMstPorts master
// ports or to an internal decode-error responder, which uses index NoMstPorts.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   test_i                 test mode, no functional effect
//   slv_req_i/slv_resp_o   upstream AXI request/response
//   mst_reqs_o/mst_resps_i downstream AXI request/response per master port
//   addr_map_i             address rules {idx, start_addr, end_addr}
//   en_default_mst_port_i  route unmatched addresses to default_mst_port_i
//   default_mst_port_i     default master port index

package axi_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } resp_t;

    typedef struct packed {
        int unsigned idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;
endpackage

module axi_slv_port_demux #(
    parameter int unsigned NoMstPorts = 2,
    parameter int unsigned NoRules    = 2,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned MaxTrans   = 8,
    parameter type req_t  = axi_pkg::req_t,
    parameter type resp_t = axi_pkg::resp_t,
    parameter type rule_t = axi_pkg::xbar_rule_64_t,
    localparam int unsigned DefW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            test_i,
    input  req_t            slv_req_i,
    output resp_t           slv_resp_o,
    output req_t            mst_reqs_o  [NoMstPorts],
    input  resp_t           mst_resps_i [NoMstPorts],
    input  rule_t           addr_map_i  [NoRules],
    input  logic            en_default_mst_port_i,
    input  logic [DefW-1:0] default_mst_port_i
);
    localparam int unsigned TgtW = $clog2(NoMstPorts + 1);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [TgtW-1:0] DecErr = TgtW'(NoMstPorts);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

    logic unused_test;
    assign unused_test = test_i;

    logic [CntW-1:0] wcnt_q, wcnt_d, wpend_q, wpend_d, rcnt_q, rcnt_d;
    logic [TgtW-1:0] wlock_q, wlock_d, rlock_q, rlock_d;
    wstate_e         wstate_q, wstate_d;
    rstate_e         rstate_q, rstate_d;
    logic [IdWidth-1:0] derr_wid_q, derr_wid_d, derr_rid_q, derr_rid_d;
    logic [7:0]      derr_len_q, derr_len_d, derr_beat_q, derr_beat_d;

    logic [TgtW-1:0] aw_tgt, ar_tgt;
    logic aw_allow, ar_allow;
    logic aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;
    logic derr_aw_valid, derr_aw_ready, derr_w_valid, derr_w_ready;
    logic derr_b_valid, derr_b_ready, derr_ar_valid, derr_ar_ready;
    logic derr_r_valid, derr_r_ready;
    axi_pkg::b_chan_t derr_b;
    axi_pkg::r_chan_t derr_r;

    // Later rules override earlier ones, so the highest matching index wins.
    // A rule with end_addr <= start_addr can never satisfy both bounds.
    function automatic logic [TgtW-1:0] decode(input logic [AddrWidth-1:0] addr);
        logic [TgtW-1:0] tgt;
        logic hit;
        tgt = DecErr;
        hit = 1'b0;
        for (int unsigned r = 0; r < NoRules; r++) begin
            if (addr >= AddrWidth'(addr_map_i[r].start_addr) &&
                addr <  AddrWidth'(addr_map_i[r].end_addr)) begin
                hit = 1'b1;
                tgt = TgtW'(addr_map_i[r].idx);
            end
        end
        if (!hit && en_default_mst_port_i) tgt = TgtW'(default_mst_port_i);
        return tgt;
    endfunction

    // Error responder outputs depend only on its own state.
    always_comb begin
        derr_aw_ready = (wstate_q == W_IDLE);
        derr_w_ready  = (wstate_q == W_DATA);
        derr_b_valid  = (wstate_q == W_RESP);
        derr_b        = '0;
        derr_b.id     = derr_wid_q;
        derr_b.resp   = 2'b11;
        derr_ar_ready = (rstate_q == R_IDLE);
        derr_r_valid  = (rstate_q == R_DATA);
        derr_r        = '0;
        derr_r.id     = derr_rid_q;
        derr_r.data[31:0] = 32'hBADCAB1E;
        derr_r.resp   = 2'b11;
        derr_r.last   = (derr_beat_q == derr_len_q);
    end

    always_comb begin
        aw_tgt   = decode(slv_req_i.aw.addr);
        ar_tgt   = decode(slv_req_i.ar.addr);
        aw_allow = (wcnt_q == '0) || (aw_tgt == wlock_q && wcnt_q < CntW'(MaxTrans));
        ar_allow = (rcnt_q == '0) || (ar_tgt == rlock_q && rcnt_q < CntW'(MaxTrans));

        slv_resp_o    = '0;
        derr_aw_valid = 1'b0;
        derr_w_valid  = 1'b0;
        derr_b_ready  = 1'b0;
        derr_ar_valid = 1'b0;
        derr_r_ready  = 1'b0;
        for (int unsigned i = 0; i < NoMstPorts; i++) begin
            mst_reqs_o[i]          = slv_req_i;
            mst_reqs_o[i].aw_valid = 1'b0;
            mst_reqs_o[i].w_valid  = 1'b0;
            mst_reqs_o[i].b_ready  = 1'b0;
            mst_reqs_o[i].ar_valid = 1'b0;
            mst_reqs_o[i].r_ready  = 1'b0;
        end

        if (aw_allow && aw_tgt == DecErr) begin
            derr_aw_valid       = slv_req_i.aw_valid;
            slv_resp_o.aw_ready = derr_aw_ready;
        end
        if (wpend_q != '0 && wlock_q == DecErr) begin
            derr_w_valid       = slv_req_i.w_valid;
            slv_resp_o.w_ready = derr_w_ready;
        end
        if (wcnt_q != '0 && wlock_q == DecErr) begin
            derr_b_ready       = slv_req_i.b_ready;
            slv_resp_o.b       = derr_b;
            slv_resp_o.b_valid = derr_b_valid;
        end
        if (ar_allow && ar_tgt == DecErr) begin
            derr_ar_valid       = slv_req_i.ar_valid;
            slv_resp_o.ar_ready = derr_ar_ready;
        end
        if (rcnt_q != '0 && rlock_q == DecErr) begin
            derr_r_ready       = slv_req_i.r_ready;
            slv_resp_o.r       = derr_r;
            slv_resp_o.r_valid = derr_r_valid;
        end

        for (int unsigned i = 0; i < NoMstPorts; i++) begin
            if (aw_allow && aw_tgt == TgtW'(i)) begin
                mst_reqs_o[i].aw_valid = slv_req_i.aw_valid;
                slv_resp_o.aw_ready    = mst_resps_i[i].aw_ready;
            end
            if (wpend_q != '0 && wlock_q == TgtW'(i)) begin
                mst_reqs_o[i].w_valid = slv_req_i.w_valid;
                slv_resp_o.w_ready    = mst_resps_i[i].w_ready;
            end
            if (wcnt_q != '0 && wlock_q == TgtW'(i)) begin
                mst_reqs_o[i].b_ready = slv_req_i.b_ready;
                slv_resp_o.b          = mst_resps_i[i].b;
                slv_resp_o.b_valid    = mst_resps_i[i].b_valid;
            end
            if (ar_allow && ar_tgt == TgtW'(i)) begin
                mst_reqs_o[i].ar_valid = slv_req_i.ar_valid;
                slv_resp_o.ar_ready    = mst_resps_i[i].ar_ready;
            end
            if (rcnt_q != '0 && rlock_q == TgtW'(i)) begin
                mst_reqs_o[i].r_ready = slv_req_i.r_ready;
                slv_resp_o.r          = mst_resps_i[i].r;
                slv_resp_o.r_valid    = mst_resps_i[i].r_valid;
            end
        end

        aw_hs     = slv_req_i.aw_valid && slv_resp_o.aw_ready;
        w_last_hs = slv_req_i.w_valid && slv_resp_o.w_ready && slv_req_i.w.last;
        b_hs      = slv_resp_o.b_valid && slv_req_i.b_ready;
        ar_hs     = slv_req_i.ar_valid && slv_resp_o.ar_ready;
        r_last_hs = slv_resp_o.r_valid && slv_req_i.r_ready && slv_resp_o.r.last;

        wcnt_d  = wcnt_q;
        wpend_d = wpend_q;
        rcnt_d  = rcnt_q;
        wlock_d = aw_hs ? aw_tgt : wlock_q;
        rlock_d = ar_hs ? ar_tgt : rlock_q;
        if (aw_hs && !b_hs)      wcnt_d  = wcnt_q + CntW'(1);
        else if (!aw_hs && b_hs) wcnt_d  = wcnt_q - CntW'(1);
        if (aw_hs && !w_last_hs)      wpend_d = wpend_q + CntW'(1);
        else if (!aw_hs && w_last_hs) wpend_d = wpend_q - CntW'(1);
        if (ar_hs && !r_last_hs)      rcnt_d  = rcnt_q + CntW'(1);
        else if (!ar_hs && r_last_hs) rcnt_d  = rcnt_q - CntW'(1);
    end

    always_comb begin
        wstate_d   = wstate_q;
        derr_wid_d = derr_wid_q;
        case (wstate_q)
            W_IDLE: if (derr_aw_valid) begin
                derr_wid_d = slv_req_i.aw.id;
                wstate_d   = W_DATA;
            end
            W_DATA: if (derr_w_valid && slv_req_i.w.last) wstate_d = W_RESP;
            W_RESP: if (derr_b_ready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        derr_rid_d  = derr_rid_q;
        derr_len_d  = derr_len_q;
        derr_beat_d = derr_beat_q;
        case (rstate_q)
            R_IDLE: if (derr_ar_valid) begin
                derr_rid_d  = slv_req_i.ar.id;
                derr_len_d  = slv_req_i.ar.len;
                derr_beat_d = '0;
                rstate_d    = R_DATA;
            end
            R_DATA: if (derr_r_ready) begin
                if (derr_beat_q == derr_len_q) rstate_d = R_IDLE;
                else derr_beat_d = derr_beat_q + 8'd1;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q      <= '0;
            wpend_q     <= '0;
            rcnt_q      <= '0;
            wlock_q     <= '0;
            rlock_q     <= '0;
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            derr_wid_q  <= '0;
            derr_rid_q  <= '0;
            derr_len_q  <= '0;
            derr_beat_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            wpend_q     <= wpend_d;
            rcnt_q      <= rcnt_d;
            wlock_q     <= wlock_d;
            rlock_q     <= rlock_d;
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            derr_wid_q  <= derr_wid_d;
            derr_rid_q  <= derr_rid_d;
            derr_len_q  <= derr_len_d;
            derr_beat_q <= derr_beat_d;
        end
    end
endmodule

// File: tb/tb_axi_slv_port_demux.sv
// Directed bench for axi_slv_port_demux with two master ports and two rules.
module tb_axi_slv_port_demux;
    logic clk = 1'b0;
    logic rst_n;
    logic test_mode;
    axi_pkg::req_t         slv_req;
    axi_pkg::resp_t        slv_resp;
    axi_pkg::req_t         mst_reqs  [2];
    axi_pkg::resp_t        mst_resps [2];
    axi_pkg::xbar_rule_64_t addr_map [2];
    logic en_def;
    logic [0:0] def_port;
    int n_assert;
    int n_fail;

    always #5 clk = ~clk;

    axi_slv_port_demux #(
        .NoMstPorts(2),
        .NoRules(2),
        .AddrWidth(64),
        .IdWidth(4),
        .MaxTrans(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .test_i(test_mode),
        .slv_req_i(slv_req),
        .slv_resp_o(slv_resp),
        .mst_reqs_o(mst_reqs),
        .mst_resps_i(mst_resps),
        .addr_map_i(addr_map),
        .en_default_mst_port_i(en_def),
        .default_mst_port_i(def_port)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic base_map();
        addr_map[0] = '{idx: 0, start_addr: 64'h0,    end_addr: 64'h1000};
        addr_map[1] = '{idx: 1, start_addr: 64'h1000, end_addr: 64'h2000};
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n     = 1'b0;
        test_mode = 1'b0;
        slv_req   = '0;
        en_def    = 1'b0;
        def_port  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mst_resps[i] = '0;
            mst_resps[i].aw_ready = 1'b1;
            mst_resps[i].w_ready  = 1'b1;
            mst_resps[i].ar_ready = 1'b1;
        end
        base_map();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_valid", 64'(slv_resp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(slv_resp.r_valid), 64'd0);
        chk("rst_w_ready", 64'(slv_resp.w_ready), 64'd0);
        chk("rst_p0_aw_valid", 64'(mst_reqs[0].aw_valid), 64'd0);
        chk("rst_p1_ar_valid", 64'(mst_reqs[1].ar_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Write to port 1 through the full AW/W/B sequence.
        slv_req.aw.addr = 64'h1800; slv_req.aw.id = 4'd3; slv_req.aw.len = 8'd0;
        slv_req.aw_valid = 1'b1;
        #1;
        chk("t1_p1_aw_valid", 64'(mst_reqs[1].aw_valid), 64'd1);
        chk("t1_p0_aw_valid", 64'(mst_reqs[0].aw_valid), 64'd0);
        chk("t1_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data = 64'h1234; slv_req.w.last = 1'b1; slv_req.w_valid = 1'b1;
        #1;
        chk("t1_p1_w_valid", 64'(mst_reqs[1].w_valid), 64'd1);
        chk("t1_p0_w_valid", 64'(mst_reqs[0].w_valid), 64'd0);
        chk("t1_w_ready", 64'(slv_resp.w_ready), 64'd1);
        tick();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        mst_resps[1].b_valid = 1'b1; mst_resps[1].b.id = 4'd3; mst_resps[1].b.resp = 2'b00;
        slv_req.b_ready = 1'b1;
        #1;
        chk("t1_b_valid", 64'(slv_resp.b_valid), 64'd1);
        chk("t1_b_id", 64'(slv_resp.b.id), 64'd3);
        chk("t1_b_resp", 64'(slv_resp.b.resp), 64'd0);
        chk("t1_p1_b_ready", 64'(mst_reqs[1].b_ready), 64'd1);
        chk("t1_p0_b_ready", 64'(mst_reqs[0].b_ready), 64'd0);
        tick();
        mst_resps[1].b_valid = 1'b0; slv_req.b_ready = 1'b0;
        #1;
        chk("t1_b_done", 64'(slv_resp.b_valid), 64'd0);
        tick();

        // Unmapped read, default disabled: decode-error burst of four beats.
        slv_req.ar.addr = 64'h5000; slv_req.ar.id = 4'd5; slv_req.ar.len = 8'd3;
        slv_req.ar_valid = 1'b1;
        #1;
        chk("t2_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
        chk("t2_p0_ar_valid", 64'(mst_reqs[0].ar_valid), 64'd0);
        chk("t2_p1_ar_valid", 64'(mst_reqs[1].ar_valid), 64'd0);
        chk("t2_r_valid_early", 64'(slv_resp.r_valid), 64'd0);
        tick();
        slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t2_r_valid_%0d", b), 64'(slv_resp.r_valid), 64'd1);
            chk($sformatf("t2_r_data_%0d", b), slv_resp.r.data, 64'hBADCAB1E);
            chk($sformatf("t2_r_resp_%0d", b), 64'(slv_resp.r.resp), 64'd3);
            chk($sformatf("t2_r_id_%0d", b), 64'(slv_resp.r.id), 64'd5);
            chk($sformatf("t2_r_last_%0d", b), 64'(slv_resp.r.last), (b == 3) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t2_r_done", 64'(slv_resp.r_valid), 64'd0);
        slv_req.r_ready = 1'b0;
        tick();

        // Same address with the default port enabled (no clock edge while valid).
        en_def = 1'b1; def_port = 1'b0; slv_req.ar_valid = 1'b1;
        #1;
        chk("t3_p0_ar_valid", 64'(mst_reqs[0].ar_valid), 64'd1);
        chk("t3_p1_ar_valid", 64'(mst_reqs[1].ar_valid), 64'd0);
        chk("t3_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
        chk("t3_r_valid", 64'(slv_resp.r_valid), 64'd0);
        def_port = 1'b1;
        #1;
        chk("t3_def1_p1_ar_valid", 64'(mst_reqs[1].ar_valid), 64'd1);
        slv_req.ar_valid = 1'b0; en_def = 1'b0; def_port = 1'b0;
        tick();

        // Overlapping rules: the higher rule index wins.
        addr_map[0].end_addr = 64'h2000;
        slv_req.aw.addr = 64'h1800; slv_req.aw_valid = 1'b1;
        #1;
        chk("t4_ovl_p1_aw_valid", 64'(mst_reqs[1].aw_valid), 64'd1);
        chk("t4_ovl_p0_aw_valid", 64'(mst_reqs[0].aw_valid), 64'd0);
        slv_req.aw_valid = 1'b0;
        base_map();
        tick();
        // Rule boundaries and a degenerate rule.
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h0FFF;
        #1;
        chk("t4_0fff_p0", 64'(mst_reqs[0].ar_valid), 64'd1);
        slv_req.ar.addr = 64'h1000;
        #1;
        chk("t4_1000_p1", 64'(mst_reqs[1].ar_valid), 64'd1);
        chk("t4_1000_p0", 64'(mst_reqs[0].ar_valid), 64'd0);
        slv_req.ar.addr = 64'h2000;
        #1;
        chk("t4_2000_p0", 64'(mst_reqs[0].ar_valid), 64'd0);
        chk("t4_2000_p1", 64'(mst_reqs[1].ar_valid), 64'd0);
        chk("t4_2000_derr_ready", 64'(slv_resp.ar_ready), 64'd1);
        addr_map[1].start_addr = 64'h2000; addr_map[1].end_addr = 64'h1000;
        slv_req.ar.addr = 64'h1800;
        #1;
        chk("t4_degen_p1", 64'(mst_reqs[1].ar_valid), 64'd0);
        chk("t4_degen_p0", 64'(mst_reqs[0].ar_valid), 64'd0);
        slv_req.ar_valid = 1'b0;
        base_map();
        tick();

        // Unmapped write: W sunk, B with DECERR one cycle after w.last.
        slv_req.aw.addr = 64'h5000; slv_req.aw.id = 4'd9; slv_req.aw_valid = 1'b1;
        #1;
        chk("t5_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        chk("t5_p0_aw_valid", 64'(mst_reqs[0].aw_valid), 64'd0);
        chk("t5_p1_aw_valid", 64'(mst_reqs[1].aw_valid), 64'd0);
        tick();
        slv_req.aw_valid = 1'b0; slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0;
        #1;
        chk("t5_w_ready", 64'(slv_resp.w_ready), 64'd1);
        chk("t5_p0_w_valid", 64'(mst_reqs[0].w_valid), 64'd0);
        tick();
        slv_req.w.last = 1'b1;
        #1;
        chk("t5_b_early", 64'(slv_resp.b_valid), 64'd0);
        tick();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        #1;
        chk("t5_b_valid", 64'(slv_resp.b_valid), 64'd1);
        chk("t5_b_resp", 64'(slv_resp.b.resp), 64'd3);
        chk("t5_b_id", 64'(slv_resp.b.id), 64'd9);
        tick();
        chk("t5_b_hold", 64'(slv_resp.b_valid), 64'd1);
        slv_req.b_ready = 1'b1;
        tick();
        slv_req.b_ready = 1'b0;
        #1;
        chk("t5_b_done", 64'(slv_resp.b_valid), 64'd0);
        tick();

        // Write lock: AW to port 1 stalls until port 0's B returns.
        slv_req.aw.addr = 64'h0100; slv_req.aw.id = 4'd1; slv_req.aw_valid = 1'b1;
        #1;
        chk("t6_p0_aw_valid", 64'(mst_reqs[0].aw_valid), 64'd1);
        tick();
        slv_req.aw.addr = 64'h1100; slv_req.aw.id = 4'd2;
        #1;
        chk("t6_stall_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
        chk("t6_stall_p1_aw_valid", 64'(mst_reqs[1].aw_valid), 64'd0);
        slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
        tick();
        slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
        mst_resps[0].b_valid = 1'b1; mst_resps[0].b.id = 4'd1; slv_req.b_ready = 1'b1;
        #1;
        chk("t6_b_valid", 64'(slv_resp.b_valid), 64'd1);
        chk("t6_b_id", 64'(slv_resp.b.id), 64'd1);
        chk("t6_stall_b_cycle", 64'(slv_resp.aw_ready), 64'd0);
        tick();
        mst_resps[0].b_valid = 1'b0; slv_req.b_ready = 1'b0;
        #1;
        chk("t6_p1_aw_valid", 64'(mst_reqs[1].aw_valid), 64'd1);
        chk("t6_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        tick();
        slv_req.aw_valid = 1'b0;

        // Read outstanding limit: the 9th AR stalls until one R with last.
        slv_req.ar.addr = 64'h0100; slv_req.ar.id = 4'd0; slv_req.ar_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t7_ar_ready_full", 64'(slv_resp.ar_ready), 64'd0);
        chk("t7_p0_ar_valid_full", 64'(mst_reqs[0].ar_valid), 64'd0);
        mst_resps[0].r_valid = 1'b1; mst_resps[0].r.last = 1'b1; slv_req.r_ready = 1'b1;
        #1;
        chk("t7_r_valid", 64'(slv_resp.r_valid), 64'd1);
        chk("t7_p0_r_ready", 64'(mst_reqs[0].r_ready), 64'd1);
        chk("t7_ar_ready_r_cycle", 64'(slv_resp.ar_ready), 64'd0);
        tick();
        mst_resps[0].r_valid = 1'b0; mst_resps[0].r.last = 1'b0; slv_req.r_ready = 1'b0;
        #1;
        chk("t7_ar_ready_after", 64'(slv_resp.ar_ready), 64'd1);
        chk("t7_p0_ar_valid_after", 64'(mst_reqs[0].ar_valid), 64'd1);
        tick();
        slv_req.ar_valid = 1'b0;

        // Reset while a write to port 1 is still open.
        slv_req.w_valid = 1'b1;
        #1;
        chk("t8_p1_w_valid", 64'(mst_reqs[1].w_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_p1_w_valid", 64'(mst_reqs[1].w_valid), 64'd0);
        chk("t8_rst_w_ready", 64'(slv_resp.w_ready), 64'd0);
        slv_req.w_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
